dead_band_gen: RTL and testbench
================================

// Module: dead_band_gen
// PURPOSE
//   Dead-band stage placed directly downstream of the PWM head's action-qualifier output.
//   Takes the raw single-ended PWM waveform T_in and produces two complementary gate drives,
//   PWM_A and PWM_B.
//   Every transition of T_in inserts a programmable dead time during which both outputs are low.
//   Delay values are double-buffered and update only at counter-zero (Ctr_0).
//   This avoids mid-period glitches.
// PARAMETERS
//   DW       10   width of the delay values and of the delay counter
//   RED_RST  10   rising-edge delay (cycles) loaded into the active register at reset
//   FED_RST  10   falling-edge delay (cycles) loaded into the active register at reset
// PORTS
//   Clock      in   1   single clock; all state updates on posedge
//   Rst_n      in   1   asynchronous, active-low reset
//   En         in   1   block enable; 0 forces both outputs low
//   T_in       in   1   raw PWM from the action qualifier; 1 requests PWM_A, 0 requests PWM_B
//   Ctr_0      in   1   counter-zero strobe from the PWM counter
//   Load_en    in   1   arms a shadow-to-active delay transfer
//   Rise_dly   in   DW  shadow rising-edge delay in cycles (dead time before PWM_A rises)
//   Fall_dly   in   DW  shadow falling-edge delay in cycles (dead time before PWM_B rises)
//   PWM_A      out  1   high-side drive, registered
//   PWM_B      out  1   low-side drive, registered
//   Dead       out  1   1 while both outputs are low (IDLE or a DLY_* state), registered
// BEHAVIOUR
//   Reset (Rst_n=0, async):
//     - PWM_A=0, PWM_B=0, Dead=1
//     - state=IDLE, cnt=0, t_q=0
//     - red_act=RED_RST, fed_act=FED_RST
//   t_q is a register sampling T_in every edge.
//   An edge is detected at a clock edge when T_in != t_q; state acts on it at that same edge.
//   Effective delay: D_eff = max(D,1), so the minimum dead time is 1 cycle and 0 means 1.
//   States (outputs registered, taking the value of the state being entered):
//     IDLE      A=0 B=0. If En=1: go to DLY_RISE if T_in=1, else DLY_FALL (counter loaded as below).
//     DLY_RISE  A=0 B=0. If cnt!=0: cnt--. If cnt==0: go to A_ON.
//     A_ON      A=1 B=0. On a T_in fall: go to DLY_FALL with cnt=max(fed_act,1)-1.
//     DLY_FALL  A=0 B=0. If cnt!=0: cnt--. If cnt==0: go to B_ON.
//     B_ON      A=0 B=1. On a T_in rise: go to DLY_RISE with cnt=max(red_act,1)-1.
//   Entering DLY_RISE from any state loads cnt=max(red_act,1)-1; DLY_FALL loads max(fed_act,1)-1.
//   Timing: for an edge detected at clock edge k, the driving output drops at edge k.
//   The opposite output rises at edge k+D_eff.
//   Short pulse: a T_in reversal while in a DLY_* state aborts the current delay.
//     - Go to the opposite DLY_* state and reload cnt from that state's delay.
//     - Outputs stay 0/0 throughout.
//   Invariant: PWM_A & PWM_B == 0 in every cycle, including after reset and after En toggles.
//   En=0 (synchronous): go to IDLE at the next edge, with A=B=0 and cnt=0.
//     - Takes priority over all transitions.
//     - Re-enable always passes through a full dead time.
//   Shadow load: at an edge with Ctr_0=1 and Load_en=1, red_act<=Rise_dly and fed_act<=Fall_dly.
//     - A delay already counting keeps its loaded cnt; the new values apply from the next DLY_* entry.
//     - Load with Ctr_0=0 has no effect.
//   Width: cnt and the active registers are DW bits, unsigned.
//     - Rise_dly/Fall_dly = 2^DW-1 is legal.
//     - No wrap: cnt saturates at 0.
//   Asynchronous reset mid-delay: outputs go low immediately, and state and delays return to reset values.
// TESTING
//   1 Reset, En=1, T_in=0, defaults -> A=B=0 for 10 cycles, then B=1 at edge 10 after first En edge; A never 1.
//   2 RED=5, FED=3; T_in 0->1 seen at edge k -> B=0 at k, A=1 at k+5.
//     Then T_in 1->0 seen at edge m -> A=0 at m, B=1 at m+3.
//   3 RED=FED=0 -> behaves as 1: exactly one 0/0 cycle on every transition.
//   4 RED=8; T_in high for 3 cycles then low (pulse < dead time) -> A stays 0 throughout.
//     B returns to 1 max(FED,1) edges after the fall is detected.
//   5 Load_en=1 with Rise_dly=20 at Ctr_0=0 -> no change.
//     Same load at Ctr_0=1 -> next rising transition has 20-cycle dead time.
//   6 Assert Rst_n=0 mid-DLY_RISE, and separately drop En while A_ON.
//     -> Outputs 0 immediately (reset) / next edge (En).
//     -> Assertion A&B==0 holds over random T_in/En/delay stimulus.

Source files
------------

// File: rtl/dead_band_gen.sv
// -----------------------------------------------------------------------------
// dead_band_gen
//   Dead-band stage that follows the PWM action qualifier. The raw single-ended
//   PWM waveform T_in is split into two complementary gate drives, PWM_A
//   (high side) and PWM_B (low side). Every transition of T_in inserts a
//   programmable dead time during which both drives are low. The rising- and
//   falling-edge delays are double-buffered. They move from the shadow inputs
//   into the active registers only at counter-zero, which keeps the dead time
//   from changing in the middle of a PWM period.
//
// Parameters
//   DW       width of the delay values and of the delay counter
//   RED_RST  rising-edge delay (cycles) held in the active register after reset
//   FED_RST  falling-edge delay (cycles) held in the active register after reset
//
// Ports
//   Clock     in   1   clock, all state updates on posedge
//   Rst_n     in   1   asynchronous active-low reset
//   En        in   1   block enable; 0 drives both outputs low via IDLE
//   T_in      in   1   raw PWM; 1 requests PWM_A, 0 requests PWM_B
//   Ctr_0     in   1   counter-zero strobe from the PWM counter
//   Load_en   in   1   arms a shadow-to-active delay transfer at Ctr_0
//   Rise_dly  in   DW  shadow dead time before PWM_A rises
//   Fall_dly  in   DW  shadow dead time before PWM_B rises
//   PWM_A     out  1   high-side drive, registered
//   PWM_B     out  1   low-side drive, registered
//   Dead      out  1   1 while both drives are low, registered
// -----------------------------------------------------------------------------
module dead_band_gen #(
  parameter int DW      = 10,
  parameter int RED_RST = 10,
  parameter int FED_RST = 10
) (
  input  logic          Clock,
  input  logic          Rst_n,
  input  logic          En,
  input  logic          T_in,
  input  logic          Ctr_0,
  input  logic          Load_en,
  input  logic [DW-1:0] Rise_dly,
  input  logic [DW-1:0] Fall_dly,
  output logic          PWM_A,
  output logic          PWM_B,
  output logic          Dead
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DLY_RISE = 3'd1,
    A_ON     = 3'd2,
    DLY_FALL = 3'd3,
    B_ON     = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   red_act_q, fed_act_q;
  logic            t_q;
  logic            a_q, a_d;
  logic            b_q, b_d;
  logic            dead_q, dead_d;
  logic            rise, fall;

  // Counter preload for a delay of d cycles. A delay of 0 is treated as 1,
  // so the load value is max(d,1)-1 and never wraps.
  function automatic logic [DW-1:0] dly_load(input logic [DW-1:0] d);
    if (d == '0) begin
      return '0;
    end
    return d - DW'(1);
  endfunction

  // Edges are judged against the value of T_in seen at the previous clock.
  assign rise = T_in & ~t_q;
  assign fall = ~T_in & t_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    if (!En) begin
      // Disable wins over every transition and clears the counter. The next
      // enable starts from IDLE, so it always passes through a full dead time.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (T_in) begin
            state_d = DLY_RISE;
            cnt_d   = dly_load(red_act_q);
          end else begin
            state_d = DLY_FALL;
            cnt_d   = dly_load(fed_act_q);
          end
        end
        DLY_RISE: begin
          // A reversal during the delay aborts it and restarts the opposite delay.
          if (fall) begin
            state_d = DLY_FALL;
            cnt_d   = dly_load(fed_act_q);
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DW'(1);
          end else begin
            state_d = A_ON;
          end
        end
        A_ON: begin
          if (fall) begin
            state_d = DLY_FALL;
            cnt_d   = dly_load(fed_act_q);
          end
        end
        DLY_FALL: begin
          if (rise) begin
            state_d = DLY_RISE;
            cnt_d   = dly_load(red_act_q);
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DW'(1);
          end else begin
            state_d = B_ON;
          end
        end
        B_ON: begin
          if (rise) begin
            state_d = DLY_RISE;
            cnt_d   = dly_load(red_act_q);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are registered and take the value of the state being entered.
    a_d    = (state_d == A_ON);
    b_d    = (state_d == B_ON);
    dead_d = ~(a_d | b_d);
  end

  always_ff @(posedge Clock or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      t_q       <= 1'b0;
      red_act_q <= DW'(RED_RST);
      fed_act_q <= DW'(FED_RST);
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      dead_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= T_in;
      // A delay already counting keeps its loaded count. New values are used
      // from the next DLY_* entry onward.
      if (Ctr_0 && Load_en) begin
        red_act_q <= Rise_dly;
        fed_act_q <= Fall_dly;
      end
      a_q    <= a_d;
      b_q    <= b_d;
      dead_q <= dead_d;
    end
  end

  assign PWM_A = a_q;
  assign PWM_B = b_q;
  assign Dead  = dead_q;

endmodule

// File: tb/tb_dead_band_gen.sv
// -----------------------------------------------------------------------------
// tb_dead_band_gen
//   Directed vectors for dead_band_gen. Every stimulus cycle pushes the
//   hand-computed {PWM_A, PWM_B, Dead} expected after the following clock edge.
//   A separate monitor pops and compares one entry per clock. The monitor also
//   checks, on every clock, that the two drives are never high together and
//   that Dead matches both drives being low. A closing random phase drives
//   T_in, En and the delays to exercise that invariant.
// -----------------------------------------------------------------------------
module tb_dead_band_gen;

  localparam int DW = 10;
  localparam logic [2:0] DD = 3'b001;  // both low, Dead=1
  localparam logic [2:0] AA = 3'b100;  // PWM_A on
  localparam logic [2:0] BB = 3'b010;  // PWM_B on

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          en    = 1'b0;
  logic          t_in  = 1'b0;
  logic          ctr0  = 1'b0;
  logic          load  = 1'b0;
  logic [DW-1:0] rd    = '0;
  logic [DW-1:0] fd    = '0;
  logic          pwm_a, pwm_b, dead;

  typedef struct {
    logic [2:0] exp;
    int         id;
  } item_t;

  item_t sb[$];
  int    total = 0;
  int    bad   = 0;
  int    step  = 0;

  dead_band_gen #(.DW(DW), .RED_RST(10), .FED_RST(10)) dut (
    .Clock    (clk),
    .Rst_n    (rst_n),
    .En       (en),
    .T_in     (t_in),
    .Ctr_0    (ctr0),
    .Load_en  (load),
    .Rise_dly (rd),
    .Fall_dly (fd),
    .PWM_A    (pwm_a),
    .PWM_B    (pwm_b),
    .Dead     (dead)
  );

  always #5 clk = ~clk;

  // One stimulus cycle: drive at the falling edge and record the expected
  // outputs after the next rising edge.
  task automatic cyc(input logic e, input logic t, input logic [2:0] x);
    @(negedge clk);
    en   = e;
    t_in = t;
    ctr0 = 1'b0;
    load = 1'b0;
    step++;
    sb.push_back('{exp: x, id: step});
  endtask

  // Stimulus cycle that also presents a shadow load.
  task automatic ld(input logic c, input logic [DW-1:0] r, input logic [DW-1:0] f,
                    input logic t, input logic [2:0] x);
    @(negedge clk);
    en   = 1'b1;
    t_in = t;
    ctr0 = c;
    load = 1'b1;
    rd   = r;
    fd   = f;
    step++;
    sb.push_back('{exp: x, id: step});
  endtask

  // Immediate check used for asynchronous reset behaviour between clock edges.
  task automatic check_now(input logic [2:0] x, input string nm);
    total++;
    if ({pwm_a, pwm_b, dead} !== x) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", nm, {pwm_a, pwm_b, dead}, x);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    item_t it;
    #1;
    total++;
    if ((pwm_a & pwm_b) !== 1'b0 || dead !== ~(pwm_a | pwm_b)) begin
      bad++;
      $display("FAIL invariant t=%0t got A=%b B=%b Dead=%b exp A&B=0 Dead=~(A|B)",
               $time, pwm_a, pwm_b, dead);
    end
    if (sb.size() > 0) begin
      it = sb.pop_front();
      total++;
      if ({pwm_a, pwm_b, dead} !== it.exp) begin
        bad++;
        $display("FAIL step%0d got=%b exp=%b", it.id, {pwm_a, pwm_b, dead}, it.exp);
      end
    end
  end

  initial begin
    // Reset state held over two edges.
    cyc(0, 0, DD);
    cyc(0, 0, DD);

    // Default delays: B rises 10 edges after the first enabled edge.
    cyc(1, 0, DD); rst_n = 1'b1;
    repeat (9) cyc(1, 0, DD);
    repeat (3) cyc(1, 0, BB);

    // RED=5, FED=3.
    ld(1, 10'd5, 10'd3, 0, BB);
    repeat (5) cyc(1, 1, DD);
    repeat (3) cyc(1, 1, AA);
    repeat (3) cyc(1, 0, DD);
    repeat (2) cyc(1, 0, BB);

    // Zero delays behave as one cycle.
    ld(1, 10'd0, 10'd0, 0, BB);
    cyc(1, 1, DD);
    repeat (2) cyc(1, 1, AA);
    cyc(1, 0, DD);
    repeat (2) cyc(1, 0, BB);

    // Short pulse: RED=8, high for 3 cycles, A never rises.
    ld(1, 10'd8, 10'd3, 0, BB);
    repeat (3) cyc(1, 1, DD);
    repeat (3) cyc(1, 0, DD);
    repeat (2) cyc(1, 0, BB);

    // Load without Ctr_0 is ignored: still RED=8.
    ld(0, 10'd20, 10'd3, 0, BB);
    repeat (8) cyc(1, 1, DD);
    cyc(1, 1, AA);
    repeat (3) cyc(1, 0, DD);
    cyc(1, 0, BB);

    // Load with Ctr_0 takes effect: RED=20.
    ld(1, 10'd20, 10'd3, 0, BB);
    repeat (20) cyc(1, 1, DD);
    repeat (2) cyc(1, 1, AA);

    // Load during a running delay keeps the running count (FED=3).
    cyc(1, 0, DD);
    ld(1, 10'd2, 10'd6, 0, DD);
    cyc(1, 0, DD);
    cyc(1, 0, BB);
    repeat (2) cyc(1, 1, DD);
    cyc(1, 1, AA);

    // En drop while A_ON, then re-enable through a full dead time (RED=2).
    repeat (2) cyc(0, 1, DD);
    repeat (2) cyc(1, 1, DD);
    cyc(1, 1, AA);

    // Reset mid-DLY_RISE restores the default delay of 10.
    repeat (6) cyc(1, 0, DD);
    cyc(1, 0, BB);
    cyc(1, 1, DD);
    cyc(1, 1, DD); rst_n = 1'b0; #1; check_now(DD, "rst_mid_rise");
    cyc(1, 1, DD);
    cyc(1, 1, DD); rst_n = 1'b1;
    repeat (9) cyc(1, 1, DD);
    cyc(1, 1, AA);

    // Asynchronous reset while A_ON drops A without a clock edge.
    cyc(1, 1, DD); rst_n = 1'b0; #1; check_now(DD, "rst_async_aon");
    cyc(0, 0, DD); rst_n = 1'b1;

    // Random T_in/En/delay activity; only the invariant is checked here.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) t_in = ~t_in;
      en   = ($urandom_range(0, 15) != 0);
      ctr0 = 1'($urandom_range(0, 1));
      load = 1'($urandom_range(0, 1));
      rd   = DW'($urandom_range(0, 5));
      fd   = DW'($urandom_range(0, 5));
    end

    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got=%0d exp=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
